dq_window_cal: RTL and testbench

- Parametrised successor to the bank-wide DQ read calibrator, generalised to LANES data pins and 2^TAP_BITS delay taps.
- New capability: per-lane window centring (each lane gets its own delay target) or legacy shared-window mode, plus per-lane failure reporting and window readback.
- Sits between the main memory FSM (which issues calibration reads) and the DQ IOB delay controls of one I/O bank, in the MCLK90 domain.

---
 rtl/dq_window_cal_pkg.sv | 37 +++
 rtl/dq_window_cal_lane_win_tracker.sv | 88 ++++++++
 rtl/dq_window_cal.sv | 184 ++++++++++++++++++
 tb/tb_dq_window_cal.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dq_window_cal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dq_window_cal_pkg
//  Description : Shared types and helpers for the DQ read-window calibrator:
//                top-level state encoding, per-lane tracker encoding and the
//                lane-good decode of a calibration read pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package dq_window_cal_pkg;

  localparam int CAL_STATE_W = 3;
  localparam int TRK_STATE_W = 2;

  // Top-level calibration sequence
  typedef enum logic [CAL_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_REZERO = 3'd2,
    ST_CENTRE = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } cal_state_e;

  // Per-lane window search
  typedef enum logic [TRK_STATE_W-1:0] {
    TRK_SEEK   = 2'd0,
    TRK_INWIN  = 2'd1,
    TRK_CLOSED = 2'd2
  } trk_state_e;

  // A lane read is good when the pair came back as 0 then 1.
  function automatic logic lane_good(input logic [1:0] pair);
    return ~pair[0] & pair[1];
  endfunction

endpackage : dq_window_cal_pkg
`default_nettype wire

// File: rtl/dq_window_cal_lane_win_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : dq_window_cal_lane_win_tracker
//  Description : Finds the first run of at least MIN_WIN consecutive good
//                taps for one lane during the sweep. Keeps window start (WS)
//                and width (WW) and flags whether a usable window exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module dq_window_cal_lane_win_tracker
  import dq_window_cal_pkg::*;
#(
  parameter int TAP_BITS = 6,
  parameter int MIN_WIN  = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                update_i,
  input  logic                good_i,
  input  logic [TAP_BITS-1:0] tap_i,
  output logic [TAP_BITS-1:0] ws_o,
  output logic [TAP_BITS:0]   ww_o,
  output logic                valid_o
);

  localparam int             NTAPS  = 1 << TAP_BITS;
  localparam logic [TAP_BITS:0] WW_MAX = (TAP_BITS+1)'(NTAPS);
  localparam logic [TAP_BITS:0] WW_MIN = (TAP_BITS+1)'(MIN_WIN);

  trk_state_e          st_q, st_d;
  logic [TAP_BITS-1:0] ws_q, ws_d;
  logic [TAP_BITS:0]   ww_q, ww_d;

  // Tracker state and window registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q <= TRK_SEEK;
      ws_q <= '0;
      ww_q <= '0;
    end else begin
      st_q <= st_d;
      ws_q <= ws_d;
      ww_q <= ww_d;
    end
  end

  // Window search: open on first good tap, drop short stutters, close on a
  // bad tap once the run is wide enough, then hold.
  always_comb begin
    st_d = st_q;
    ws_d = ws_q;
    ww_d = ww_q;
    if (clear_i) begin
      st_d = TRK_SEEK;
      ws_d = '0;
      ww_d = '0;
    end else if (update_i) begin
      case (st_q)
        TRK_SEEK: begin
          if (good_i) begin
            ws_d = tap_i;
            ww_d = (TAP_BITS+1)'(1);
            st_d = TRK_INWIN;
          end
        end
        TRK_INWIN: begin
          if (good_i) begin
            if (ww_q != WW_MAX) ww_d = ww_q + 1'b1;
          end else if (ww_q >= WW_MIN) begin
            st_d = TRK_CLOSED;
          end else begin
            st_d = TRK_SEEK;
            ww_d = '0;
          end
        end
        TRK_CLOSED: st_d = TRK_CLOSED;
        default:    st_d = TRK_SEEK;
      endcase
    end
  end

  assign ws_o    = ws_q;
  assign ww_o    = ww_q;
  // A window still open at the last tap counts once it is wide enough.
  assign valid_o = (st_q == TRK_CLOSED) || ((st_q == TRK_INWIN) && (ww_q >= WW_MIN));

endmodule : dq_window_cal_lane_win_tracker
`default_nettype wire

// File: rtl/dq_window_cal.sv
`default_nettype none
// ============================================================================
//  Module      : dq_window_cal
//  Description : DQ read calibration for one I/O bank. Sweeps all delay taps,
//                locates a good-data window per lane (or one shared window),
//                then re-zeroes the delays and steps each lane to the centre
//                of its window. Reports per-lane failures and window values.
//  Revision    : 1.0 - initial release
// ============================================================================
module dq_window_cal
  import dq_window_cal_pkg::*;
#(
  parameter int LANES    = 12,
  parameter int TAP_BITS = 6,
  parameter int MIN_WIN  = 5,
  parameter int PER_LANE = 1
) (
  input  logic                          MCLK90,
  input  logic                          M90ResetL,
  input  logic                          Start,
  input  logic                          ReadValid,
  input  logic [2*LANES-1:0]            RB,
  output logic [LANES-1:0]              DlyInc,
  output logic                          DlyReset,
  output logic                          CalBusy,
  output logic                          CalDone,
  output logic                          CalFail,
  output logic [LANES-1:0]              FailLane,
  output logic [LANES*TAP_BITS-1:0]     WinStart,
  output logic [LANES*(TAP_BITS+1)-1:0] WinWidth
);

  localparam int                NTAPS    = 1 << TAP_BITS;
  localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(NTAPS - 1);
  localparam logic [TAP_BITS:0]   MAX_TGT  = (TAP_BITS+1)'(NTAPS - 1);

  cal_state_e          state_q, state_d;
  logic [TAP_BITS-1:0] tap_q, tap_d;          // sweep tap t, then centre count c
  logic [LANES-1:0]    dly_inc_q, dly_inc_d;
  logic                dly_reset_q, dly_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [LANES-1:0]    fail_lane_q, fail_lane_d;

  logic                trk_clear_w;
  logic                trk_update_w;
  logic [LANES-1:0]    lane_good_w;
  logic [LANES-1:0]    g_w;
  logic [LANES-1:0]    valid_w;
  logic [LANES-1:0]    centre_inc_w;
  logic [LANES*TAP_BITS-1:0]     ws_w;
  logic [LANES*(TAP_BITS+1)-1:0] ww_w;

  // Choose what each tracker sees: its own lane, or the whole bank agreeing.
  if (PER_LANE != 0) begin : g_per_lane
    assign g_w = lane_good_w;
  end else begin : g_bank
    assign g_w = {LANES{&lane_good_w}};
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [TAP_BITS:0] sum_w;
    logic [TAP_BITS:0] tgt_w;

    assign lane_good_w[i] = lane_good(RB[2*i +: 2]);

    dq_window_cal_lane_win_tracker #(
      .TAP_BITS (TAP_BITS),
      .MIN_WIN  (MIN_WIN)
    ) u_lane_win_tracker (
      .clk_i    (MCLK90),
      .rst_ni   (M90ResetL),
      .clear_i  (trk_clear_w),
      .update_i (trk_update_w),
      .good_i   (g_w[i]),
      .tap_i    (tap_q),
      .ws_o     (ws_w[i*TAP_BITS +: TAP_BITS]),
      .ww_o     (ww_w[i*(TAP_BITS+1) +: (TAP_BITS+1)]),
      .valid_o  (valid_w[i])
    );

    // Centre of window = start + width/2, clamped to the last tap.
    assign sum_w = {1'b0, ws_w[i*TAP_BITS +: TAP_BITS]}
                 + {1'b0, ww_w[i*(TAP_BITS+1) + 1 +: TAP_BITS]};
    assign tgt_w = (sum_w > MAX_TGT) ? MAX_TGT : sum_w;
    assign centre_inc_w[i] = ({1'b0, tap_q} < tgt_w);
  end

  // State and registered output update
  always_ff @(posedge MCLK90) begin
    if (!M90ResetL) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      dly_inc_q   <= '0;
      dly_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      dly_inc_q   <= dly_inc_d;
      dly_reset_q <= dly_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_lane_q <= fail_lane_d;
    end
  end

  // Sequencing: sweep all taps, judge windows, re-zero, step to centre.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    dly_inc_d    = '0;
    dly_reset_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_lane_d  = fail_lane_q;
    trk_clear_w  = 1'b0;
    trk_update_w = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (Start) begin
          trk_clear_w = 1'b1;
          tap_d       = '0;
          dly_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_lane_d = '0;
          state_d     = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (ReadValid) begin
          trk_update_w = 1'b1;
          if (tap_q == LAST_TAP) begin
            state_d = ST_REZERO;
          end else begin
            dly_inc_d = '1;
            tap_d     = tap_q + 1'b1;
          end
        end
      end
      ST_REZERO: begin
        if (&valid_w) begin
          dly_reset_d = 1'b1;
          tap_d       = '0;
          state_d     = ST_CENTRE;
        end else begin
          fail_lane_d = ~valid_w;
          fail_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_FAIL;
        end
      end
      ST_CENTRE: begin
        dly_inc_d = centre_inc_w;
        tap_d     = tap_q + 1'b1;
        if (tap_q == LAST_TAP) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign DlyInc   = dly_inc_q;
  assign DlyReset = dly_reset_q;
  assign CalBusy  = busy_q;
  assign CalDone  = done_q;
  assign CalFail  = fail_q;
  assign FailLane = fail_lane_q;
  assign WinStart = ws_w;
  assign WinWidth = ww_w;

endmodule : dq_window_cal
`default_nettype wire

// File: tb/tb_dq_window_cal.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dq_window_cal
//  Description : Self-checking bench for dq_window_cal, per-lane and bank
//                instances driven by the same calibration reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dq_window_cal;

  localparam int LANES    = 4;
  localparam int TAP_BITS = 4;
  localparam int MIN_WIN  = 3;
  localparam int NTAPS    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_l, start, rv;
  logic [2*LANES-1:0]            rb;
  logic [LANES-1:0]              inc_a, inc_b, fl_a, fl_b;
  logic                          dr_a, dr_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;
  logic [LANES*TAP_BITS-1:0]     ws_a, ws_b;
  logic [LANES*(TAP_BITS+1)-1:0] ww_a, ww_b;

  dq_window_cal #(.LANES(LANES), .TAP_BITS(TAP_BITS), .MIN_WIN(MIN_WIN), .PER_LANE(1)) dut_a (
    .MCLK90(clk), .M90ResetL(rst_l), .Start(start), .ReadValid(rv), .RB(rb),
    .DlyInc(inc_a), .DlyReset(dr_a), .CalBusy(busy_a), .CalDone(done_a), .CalFail(fail_a),
    .FailLane(fl_a), .WinStart(ws_a), .WinWidth(ww_a));

  dq_window_cal #(.LANES(LANES), .TAP_BITS(TAP_BITS), .MIN_WIN(MIN_WIN), .PER_LANE(0)) dut_b (
    .MCLK90(clk), .M90ResetL(rst_l), .Start(start), .ReadValid(rv), .RB(rb),
    .DlyInc(inc_b), .DlyReset(dr_b), .CalBusy(busy_b), .CalDone(done_b), .CalFail(fail_b),
    .FailLane(fl_b), .WinStart(ws_b), .WinWidth(ww_b));

  int total = 0;
  int bad   = 0;

  // Observed activity, split between the sweep and what follows it
  bit in_sweep;
  int sw_inc_a[LANES], sw_inc_b[LANES], ce_inc_a[LANES], ce_inc_b[LANES];
  int sw_rst_a, sw_rst_b, ce_rst_a, ce_rst_b, sw_busy_lo;

  // Reference model results
  bit ok_a[LANES];
  int xws_a[LANES], xww_a[LANES], xtg_a[LANES];
  bit all_ok_a;
  bit ok_b;
  int xws_b, xww_b, xtg_b;

  function automatic logic [15:0] run_mask(input int lo, input int hi);
    logic [15:0] m;
    m = '0;
    for (int t = 0; t < NTAPS; t++) if (t >= lo && t <= hi) m[t] = 1'b1;
    return m;
  endfunction

  // First run of consecutive good taps at least MIN_WIN long.
  function automatic void win_model(input logic [15:0] m, output bit ok, output int ws,
                                    output int ww, output int tg);
    int t, s, len;
    ok = 0; ws = 0; ww = 0; tg = 0; t = 0;
    while (t < NTAPS) begin
      if (m[t]) begin
        s = t; len = 0;
        while (t < NTAPS && m[t]) begin len++; t++; end
        if (len >= MIN_WIN) begin
          ok = 1; ws = s; ww = len;
          tg = ws + ww / 2;
          if (tg > NTAPS - 1) tg = NTAPS - 1;
          return;
        end
      end else begin
        t++;
      end
    end
  endfunction

  task automatic compute(input logic [4*16-1:0] masks);
    logic [15:0] band;
    band = '1;
    all_ok_a = 1;
    for (int i = 0; i < LANES; i++) begin
      win_model(masks[16*i +: 16], ok_a[i], xws_a[i], xww_a[i], xtg_a[i]);
      if (!ok_a[i]) all_ok_a = 0;
      band = band & masks[16*i +: 16];
    end
    win_model(band, ok_b, xws_b, xww_b, xtg_b);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < LANES; i++) begin
      sw_inc_a[i] = 0; sw_inc_b[i] = 0; ce_inc_a[i] = 0; ce_inc_b[i] = 0;
    end
    sw_rst_a = 0; sw_rst_b = 0; ce_rst_a = 0; ce_rst_b = 0; sw_busy_lo = 0;
  endtask

  // One clock; sample 1ns after the edge and accumulate activity.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < LANES; i++) begin
      if (in_sweep) begin
        sw_inc_a[i] += int'(inc_a[i]); sw_inc_b[i] += int'(inc_b[i]);
      end else begin
        ce_inc_a[i] += int'(inc_a[i]); ce_inc_b[i] += int'(inc_b[i]);
      end
    end
    if (in_sweep) begin
      sw_rst_a += int'(dr_a); sw_rst_b += int'(dr_b);
      if (!busy_a) sw_busy_lo++;
    end else begin
      ce_rst_a += int'(dr_a); ce_rst_b += int'(dr_b);
    end
  endtask

  task automatic drive_rb(input logic [4*16-1:0] masks, input int t);
    logic [1:0] p;
    for (int i = 0; i < LANES; i++) begin
      if (masks[16*i + t]) begin
        rb[2*i +: 2] = 2'b10;
      end else begin
        p = 2'($urandom_range(0, 2));
        rb[2*i +: 2] = (p == 2'd2) ? 2'b11 : p;
      end
    end
  endtask

  // Full calibration: Start, 16 reads with random gaps, then wait for the end.
  task automatic run_cal(input logic [4*16-1:0] masks, input bit start_mid,
                         input bit rv_start, input int stop_after);
    int n;
    clear_counts();
    compute(masks);
    in_sweep = 1;
    start = 1; rv = rv_start; rb = 8'($urandom);
    tick();
    start = 0; rv = 0;
    for (int t = 0; t < NTAPS; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (start_mid && t == 8) begin start = 1; tick(); start = 0; end
      drive_rb(masks, t);
      rv = 1;
      tick();
      rv = 0;
      rb = 8'($urandom);
    end
    in_sweep = 0;
    if (stop_after >= 0) begin
      repeat (stop_after) tick();
      return;
    end
    n = 0;
    while (!((done_a || fail_a) && (done_b || fail_b)) && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL cal_timeout: no Done/Fail after %0d cycles (done_a=%b fail_a=%b)", n, done_a, fail_a);
    end
  endtask

  task automatic test_reset();
    rst_l = 0;
    repeat (3) tick();
    total++;
    if ({inc_a, dr_a, busy_a, done_a, fail_a, fl_a} !== '0) begin
      bad++; $display("FAIL reset_ctrl_a: got %b want 0", {inc_a, dr_a, busy_a, done_a, fail_a, fl_a});
    end
    total++;
    if ({ws_a, ww_a} !== '0) begin
      bad++; $display("FAIL reset_win_a: got %h want 0", {ws_a, ww_a});
    end
    total++;
    if ({inc_b, dr_b, busy_b, done_b, fail_b, fl_b, ws_b, ww_b} !== '0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {inc_b, dr_b, busy_b, done_b, fail_b, fl_b, ws_b, ww_b});
    end
    rst_l = 1;
    tick();
  endtask

  task automatic test_basic();
    run_cal({4{16'h07E0}}, 0, 0, -1);
    total++;
    if ({done_a, busy_a, fail_a} !== 3'b100) begin
      bad++; $display("FAIL basic_status: got done/busy/fail=%b want 100", {done_a, busy_a, fail_a});
    end
    total++;
    if (sw_rst_a !== 1 || ce_rst_a !== 1 || sw_busy_lo !== 0) begin
      bad++; $display("FAIL basic_reset_busy: got sweep_rst=%0d centre_rst=%0d busy_lo=%0d want 1 1 0", sw_rst_a, ce_rst_a, sw_busy_lo);
    end
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (sw_inc_a[i] !== NTAPS - 1 || sw_inc_b[i] !== NTAPS - 1) begin
        bad++; $display("FAIL basic_sweep_inc lane%0d: got %0d/%0d want %0d", i, sw_inc_a[i], sw_inc_b[i], NTAPS - 1);
      end
      total++;
      if (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ww_a[5*i +: 5] !== 5'(xww_a[i]) || ce_inc_a[i] !== xtg_a[i]) begin
        bad++; $display("FAIL basic_win lane%0d: got ws=%0d ww=%0d inc=%0d want %0d %0d %0d", i,
                        ws_a[4*i +: 4], ww_a[5*i +: 5], ce_inc_a[i], xws_a[i], xww_a[i], xtg_a[i]);
      end
      total++;
      if (ce_inc_b[i] !== xtg_b) begin
        bad++; $display("FAIL basic_bank_inc lane%0d: got %0d want %0d", i, ce_inc_b[i], xtg_b);
      end
    end
  endtask

  task automatic test_lane_shift();
    logic [15:0] o;
    o = run_mask(5, 10);
    for (int k = 0; k < 2; k++) begin
      run_cal({o, (k == 0) ? run_mask(2, 13) : run_mask(0, 7), o, o}, 0, 0, -1);
      for (int i = 0; i < LANES; i++) begin
        total++;
        if (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ww_a[5*i +: 5] !== 5'(xww_a[i]) || ce_inc_a[i] !== xtg_a[i]) begin
          bad++; $display("FAIL shift%0d lane%0d: got ws=%0d ww=%0d inc=%0d want %0d %0d %0d", k, i,
                          ws_a[4*i +: 4], ww_a[5*i +: 5], ce_inc_a[i], xws_a[i], xww_a[i], xtg_a[i]);
        end
      end
    end
  endtask

  task automatic test_stutter();
    logic [15:0] o;
    o = run_mask(5, 10);
    run_cal({o, o, o, run_mask(3, 4) | run_mask(7, 12)}, 0, 0, -1);
    total++;
    if (ws_a[3:0] !== 4'd7 || ww_a[4:0] !== 5'd6 || ce_inc_a[0] !== 10 || done_a !== 1'b1) begin
      bad++; $display("FAIL stutter: got ws=%0d ww=%0d inc=%0d done=%b want 7 6 10 1",
                      ws_a[3:0], ww_a[4:0], ce_inc_a[0], done_a);
    end
  endtask

  task automatic test_fail();
    logic [15:0] o;
    o = run_mask(5, 10);
    run_cal({o, o, 16'h0000, o}, 0, 0, -1);
    total++;
    if ({fail_a, done_a, busy_a} !== 3'b100 || fl_a !== 4'b0010) begin
      bad++; $display("FAIL fail_status: got fail/done/busy=%b lanes=%b want 100 0010", {fail_a, done_a, busy_a}, fl_a);
    end
    total++;
    if (ce_rst_a !== 0 || (ce_inc_a[0] + ce_inc_a[1] + ce_inc_a[2] + ce_inc_a[3]) !== 0) begin
      bad++; $display("FAIL fail_quiet: got dlyreset=%0d incs=%0d want 0 0", ce_rst_a,
                      ce_inc_a[0] + ce_inc_a[1] + ce_inc_a[2] + ce_inc_a[3]);
    end
    total++;
    if (fail_b !== 1'b1 || fl_b !== 4'b1111) begin
      bad++; $display("FAIL fail_bank: got fail=%b lanes=%b want 1 1111", fail_b, fl_b);
    end
    start = 1;
    tick();
    start = 0;
    total++;
    if ({fail_a, busy_a, dr_a} !== 3'b011 || fl_a !== 4'b0000) begin
      bad++; $display("FAIL fail_restart: got fail/busy/dlyreset=%b lanes=%b want 011 0000", {fail_a, busy_a, dr_a}, fl_a);
    end
    rst_l = 0; tick(); rst_l = 1; tick();
    run_cal({4{o}}, 0, 0, -1);
    total++;
    if (done_a !== 1'b1 || fail_a !== 1'b0) begin
      bad++; $display("FAIL fail_recover: got done=%b fail=%b want 1 0", done_a, fail_a);
    end
  endtask

  task automatic test_bank();
    logic [15:0] o;
    o = run_mask(2, 12);
    run_cal({run_mask(6, 8), o, o, o}, 0, 0, -1);
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (ws_b[4*i +: 4] !== 4'd6 || ww_b[5*i +: 5] !== 5'd3 || ce_inc_b[i] !== 7) begin
        bad++; $display("FAIL bank lane%0d: got ws=%0d ww=%0d inc=%0d want 6 3 7", i,
                        ws_b[4*i +: 4], ww_b[5*i +: 5], ce_inc_b[i]);
      end
      total++;
      if (ce_inc_a[i] !== xtg_a[i]) begin
        bad++; $display("FAIL bank_perlane lane%0d: got inc=%0d want %0d", i, ce_inc_a[i], xtg_a[i]);
      end
    end
    total++;
    if (done_b !== 1'b1 || fl_b !== 4'b0000) begin
      bad++; $display("FAIL bank_done: got done=%b lanes=%b want 1 0000", done_b, fl_b);
    end
  endtask

  task automatic test_boundaries();
    run_cal({16'hFFFF, run_mask(13, 15), run_mask(0, 2), 16'hFFFF}, 0, 0, -1);
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ww_a[5*i +: 5] !== 5'(xww_a[i]) || ce_inc_a[i] !== xtg_a[i]) begin
        bad++; $display("FAIL boundary lane%0d: got ws=%0d ww=%0d inc=%0d want %0d %0d %0d", i,
                        ws_a[4*i +: 4], ww_a[5*i +: 5], ce_inc_a[i], xws_a[i], xww_a[i], xtg_a[i]);
      end
    end
    run_cal({4{16'hFFFF}}, 0, 0, -1);
    total++;
    if (ws_b[3:0] !== 4'd0 || ww_b[4:0] !== 5'd16 || ce_inc_b[0] !== 8 || ce_inc_a[3] !== 8) begin
      bad++; $display("FAIL all_good: got ws=%0d ww=%0d inc_b=%0d inc_a=%0d want 0 16 8 8",
                      ws_b[3:0], ww_b[4:0], ce_inc_b[0], ce_inc_a[3]);
    end
  endtask

  task automatic test_start_in_sweep();
    run_cal({run_mask(1, 6), run_mask(4, 11), run_mask(8, 15), run_mask(3, 9)}, 1, 0, -1);
    total++;
    if (sw_rst_a !== 1 || done_a !== 1'b1) begin
      bad++; $display("FAIL start_in_sweep: got sweep_rst=%0d done=%b want 1 1", sw_rst_a, done_a);
    end
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ce_inc_a[i] !== xtg_a[i]) begin
        bad++; $display("FAIL start_in_sweep lane%0d: got ws=%0d inc=%0d want %0d %0d", i,
                        ws_a[4*i +: 4], ce_inc_a[i], xws_a[i], xtg_a[i]);
      end
    end
  endtask

  task automatic test_start_with_readvalid();
    rst_l = 0; tick(); rst_l = 1; tick();
    run_cal({run_mask(0, 4), run_mask(2, 6), run_mask(9, 14), run_mask(5, 10)}, 0, 1, -1);
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ww_a[5*i +: 5] !== 5'(xww_a[i]) || sw_inc_a[i] !== NTAPS - 1) begin
        bad++; $display("FAIL start_rv lane%0d: got ws=%0d ww=%0d sweep_inc=%0d want %0d %0d %0d", i,
                        ws_a[4*i +: 4], ww_a[5*i +: 5], sw_inc_a[i], xws_a[i], xww_a[i], NTAPS - 1);
      end
    end
  endtask

  task automatic test_reset_mid_centre();
    run_cal({4{run_mask(5, 10)}}, 0, 0, 5);
    rst_l = 0;
    tick();
    total++;
    if ({inc_a, dr_a, busy_a, done_a, fail_a, fl_a, ws_a, ww_a} !== '0) begin
      bad++; $display("FAIL mid_reset_a: got %h want 0", {inc_a, dr_a, busy_a, done_a, fail_a, fl_a, ws_a, ww_a});
    end
    total++;
    if ({inc_b, dr_b, busy_b, done_b, fail_b} !== '0) begin
      bad++; $display("FAIL mid_reset_b: got %b want 0", {inc_b, dr_b, busy_b, done_b, fail_b});
    end
    rst_l = 1;
    clear_counts();
    repeat (20) tick();
    total++;
    if (ce_rst_a !== 0 || (ce_inc_a[0] + ce_inc_a[1] + ce_inc_a[2] + ce_inc_a[3]) !== 0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++; $display("FAIL mid_reset_idle: got dlyreset=%0d busy=%b done=%b want 0 0 0", ce_rst_a, busy_a, done_a);
    end
  endtask

  task automatic test_random();
    logic [4*16-1:0] masks;
    int s, len, lo, hi;
    for (int it = 0; it < 12; it++) begin
      s   = $urandom_range(0, 12);
      len = $urandom_range(2, NTAPS - s);
      for (int i = 0; i < LANES; i++) begin
        lo = s + $urandom_range(0, 1);
        hi = s + len - 1 - $urandom_range(0, 1);
        masks[16*i +: 16] = run_mask(lo, hi) | 16'($urandom & $urandom & $urandom);
        if (it % 5 == 4 && i == 1) masks[16*i +: 16] = 16'h0000;
      end
      run_cal(masks, 0, 0, -1);
      total++;
      if (done_a !== all_ok_a || fail_a !== !all_ok_a || done_b !== ok_b || fail_b !== !ok_b) begin
        bad++; $display("FAIL rand%0d_status: got a=%b%b b=%b%b want a=%b%b b=%b%b", it, done_a, fail_a,
                        done_b, fail_b, all_ok_a, !all_ok_a, ok_b, !ok_b);
      end
      for (int i = 0; i < LANES; i++) begin
        total++;
        if (fl_a[i] !== (!all_ok_a && !ok_a[i]) || fl_b[i] !== !ok_b) begin
          bad++; $display("FAIL rand%0d_faillane lane%0d: got a=%b b=%b want a=%b b=%b", it, i, fl_a[i], fl_b[i],
                          (!all_ok_a && !ok_a[i]), !ok_b);
        end
        total++;
        if (ok_a[i] && (ws_a[4*i +: 4] !== 4'(xws_a[i]) || ww_a[5*i +: 5] !== 5'(xww_a[i]))) begin
          bad++; $display("FAIL rand%0d_win_a lane%0d: got ws=%0d ww=%0d want %0d %0d", it, i,
                          ws_a[4*i +: 4], ww_a[5*i +: 5], xws_a[i], xww_a[i]);
        end
        total++;
        if (ce_inc_a[i] !== (all_ok_a ? xtg_a[i] : 0) || ce_inc_b[i] !== (ok_b ? xtg_b : 0)) begin
          bad++; $display("FAIL rand%0d_centre lane%0d: got a=%0d b=%0d want a=%0d b=%0d", it, i, ce_inc_a[i],
                          ce_inc_b[i], all_ok_a ? xtg_a[i] : 0, ok_b ? xtg_b : 0);
        end
        total++;
        if (ok_b && (ws_b[4*i +: 4] !== 4'(xws_b) || ww_b[5*i +: 5] !== 5'(xww_b))) begin
          bad++; $display("FAIL rand%0d_win_b lane%0d: got ws=%0d ww=%0d want %0d %0d", it, i,
                          ws_b[4*i +: 4], ww_b[5*i +: 5], xws_b, xww_b);
        end
      end
      total++;
      if (ce_rst_a !== (all_ok_a ? 1 : 0) || ce_rst_b !== (ok_b ? 1 : 0)) begin
        bad++; $display("FAIL rand%0d_dlyreset: got a=%0d b=%0d want a=%0d b=%0d", it, ce_rst_a, ce_rst_b,
                        all_ok_a ? 1 : 0, ok_b ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst_l = 0; start = 0; rv = 0; rb = '0; in_sweep = 0;
    clear_counts();
    test_reset();
    test_basic();
    test_lane_shift();
    test_stutter();
    test_fail();
    test_bank();
    test_boundaries();
    test_start_in_sweep();
    test_start_with_readvalid();
    test_reset_mid_centre();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dq_window_cal
`default_nettype wire
